// File: rtl/lhs_seq_pkg.sv
// Shared types for the lhs shift sequencer and the ALU top-level decoder.
// lhs_op_t encodings are the raw operation codes of the lhs unit.
package lhs_seq_pkg;

  typedef enum logic [1:0] {
    PASS = 2'b00,
    SHL  = 2'b01,
    SHR  = 2'b10,
    ZERO = 2'b11
  } lhs_op_t;

  typedef enum logic [1:0] {
    LOGICAL = 2'b00,
    ROTATE  = 2'b01,
    ARITH   = 2'b10,
    CLEAR   = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2
  } seq_state_t;

endpackage

// File: rtl/lhs_sequencer.sv
// Drives the external one-bit lhs shifter for N steps, then captures its output as result/carry_out.
// Latency N+1 edges from accept to done; start is ignored while busy, with no queueing.
module lhs_sequencer
  import lhs_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             alu_clk,
  input  logic             alu_rst_n,
  input  logic             start,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    count,
  input  logic [WIDTH-1:0] operand,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic [1:0]       lhs_operation,
  output logic [WIDTH-1:0] lhs_in,
  output logic             lhs_carry_in,
  input  logic [WIDTH-1:0] lhs_out,
  input  logic             lhs_carry_out
);

  seq_state_t       state;
  lhs_op_t          op_q;
  shift_mode_t      mode_q;
  logic             dir_q;
  logic             cin_q;
  logic             first_q;
  logic [WIDTH-1:0] operand_q;
  logic [CW-1:0]    remaining;
  logic [WIDTH-1:0] step_in;

  assign busy = (state != IDLE);

  always_ff @(posedge alu_clk or negedge alu_rst_n) begin
    if (!alu_rst_n) begin
      state     <= IDLE;
      op_q      <= PASS;
      mode_q    <= LOGICAL;
      dir_q     <= 1'b0;
      cin_q     <= 1'b0;
      first_q   <= 1'b0;
      operand_q <= '0;
      remaining <= '0;
      result    <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            operand_q <= operand;
            cin_q     <= carry_in;
            dir_q     <= dir;
            mode_q    <= shift_mode_t'(mode);
            first_q   <= 1'b1;
            state     <= RUN;
            // Clear wins over a zero count; a zero count becomes one pass step.
            if (shift_mode_t'(mode) == CLEAR) begin
              op_q      <= ZERO;
              remaining <= CW'(1);
            end else if (count == '0) begin
              op_q      <= PASS;
              remaining <= CW'(1);
            end else begin
              op_q      <= dir ? SHR : SHL;
              remaining <= count;
            end
          end
        end
        RUN: begin
          first_q   <= 1'b0;
          remaining <= remaining - CW'(1);
          if (remaining == CW'(1)) state <= CAPTURE;
        end
        CAPTURE: begin
          result    <= lhs_out;
          carry_out <= lhs_carry_out;
          done      <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Step 1 sources the latched operand, so the unreset lhs contents never matter.
  assign step_in = first_q ? operand_q : lhs_out;

  always_comb begin
    lhs_operation = PASS;
    lhs_in        = result;
    lhs_carry_in  = carry_out;
    case (state)
      RUN: begin
        lhs_operation = op_q;
        lhs_in        = step_in;
        lhs_carry_in  = 1'b0;
        if (op_q == PASS) begin
          lhs_carry_in = cin_q;
        end else begin
          case (mode_q)
            ROTATE:  lhs_carry_in = first_q ? cin_q : lhs_carry_out;
            ARITH:   lhs_carry_in = dir_q & step_in[WIDTH-1];
            default: lhs_carry_in = 1'b0;
          endcase
        end
      end
      CAPTURE: begin
        lhs_in       = lhs_out;
        lhs_carry_in = lhs_carry_out;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lhs_sequencer.sv
// Bench for lhs_sequencer with a behavioural lhs shifter in the feedback loop.
// Expected results are queued at accept time and checked by an independent done monitor.
module tb_lhs_sequencer;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             alu_clk = 1'b0;
  logic             alu_rst_n = 1'b0;
  logic             start = 1'b0;
  logic             dir = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CW-1:0]    count = '0;
  logic [WIDTH-1:0] operand = '0;
  logic             carry_in = 1'b0;
  logic             busy, done, carry_out, lhs_carry_in;
  logic [WIDTH-1:0] result, lhs_in;
  logic [1:0]       lhs_operation;
  logic [WIDTH-1:0] lhs_out;
  logic             lhs_carry_out;

  lhs_sequencer #(.WIDTH(WIDTH), .CW(CW)) dut (
    .alu_clk(alu_clk), .alu_rst_n(alu_rst_n), .start(start), .dir(dir), .mode(mode),
    .count(count), .operand(operand), .carry_in(carry_in), .busy(busy), .done(done),
    .result(result), .carry_out(carry_out), .lhs_operation(lhs_operation), .lhs_in(lhs_in),
    .lhs_carry_in(lhs_carry_in), .lhs_out(lhs_out), .lhs_carry_out(lhs_carry_out)
  );

  always #5 alu_clk = ~alu_clk;

  // Behavioural lhs unit: one registered step per edge, no reset.
  always @(posedge alu_clk) begin
    case (lhs_operation)
      2'b00: begin lhs_out <= lhs_in;                          lhs_carry_out <= lhs_carry_in; end
      2'b01: begin lhs_out <= {lhs_in[WIDTH-2:0], lhs_carry_in}; lhs_carry_out <= lhs_in[WIDTH-1]; end
      2'b10: begin lhs_out <= {lhs_carry_in, lhs_in[WIDTH-1:1]}; lhs_carry_out <= lhs_in[0]; end
      default: begin lhs_out <= '0;                            lhs_carry_out <= 1'b0; end
    endcase
  end

  int cyc = 0;
  always @(posedge alu_clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       c;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   dones_seen = 0;
  int   dones_expected = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Done monitor: every done must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge alu_clk);
      if (done) begin
        dones_seen++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL done_without_request: done seen at cycle %0d with no outstanding request", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_result"}, 32'(result), 32'(e.res));
          chk({e.name, "_carry"}, 32'(carry_out), 32'(e.c));
          chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 100 && busy; i++) @(negedge alu_clk);
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout: busy still 1 after 100 cycles", nm);
    end
  endtask

  task automatic issue(input string nm, input logic d, input logic [1:0] m, input logic [3:0] cnt,
                       input logic [7:0] opnd, input logic ci, input logic [7:0] er, input logic ec,
                       input int lat, input bit steps, input logic [1:0] eop, input logic ecin,
                       input bit b2b);
    exp_t e;
    @(negedge alu_clk);
    wait_idle(nm);
    if (b2b) chk({nm, "_issued_in_done_cycle"}, 32'(done), 32'd1);
    start = 1'b1; dir = d; mode = m; count = cnt; operand = opnd; carry_in = ci;
    @(posedge alu_clk);
    #1;
    start = 1'b0;
    e.name = nm; e.res = er; e.c = ec; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
    dones_expected++;
    @(negedge alu_clk);
    chk({nm, "_busy_after_accept"}, 32'(busy), 32'd1);
    if (steps) begin
      for (int k = 0; k < lat - 1; k++) begin
        chk({nm, "_step_op"}, 32'(lhs_operation), 32'(eop));
        chk({nm, "_step_cin"}, 32'(lhs_carry_in), 32'(ecin));
        if (k < lat - 2) @(negedge alu_clk);
      end
    end
  endtask

  initial begin
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", 32'(result), 32'd0);
    chk("reset_lhs_in", 32'(lhs_in), 32'd0);
    repeat (2) @(negedge alu_clk);
    alu_rst_n = 1'b1;

    //    name        dir  mode   cnt  operand ci  result c  lat steps op   cin b2b
    issue("lsl3",     0, 2'b00, 4'd3,  8'h81, 0, 8'h08, 0,  4, 1, 2'b01, 0, 0);
    issue("asr2",     1, 2'b10, 4'd2,  8'h90, 0, 8'hE4, 0,  3, 1, 2'b10, 1, 0);
    issue("rcr9",     1, 2'b01, 4'd9,  8'h01, 1, 8'h01, 1, 10, 0, 2'b00, 0, 0);
    issue("pass0",    0, 2'b00, 4'd0,  8'h5A, 1, 8'h5A, 1,  2, 1, 2'b00, 1, 0);
    issue("clear",    0, 2'b11, 4'd5,  8'hFF, 1, 8'h00, 0,  2, 0, 2'b11, 0, 1);
    issue("asl1",     0, 2'b10, 4'd1,  8'h81, 1, 8'h02, 1,  2, 1, 2'b01, 0, 0);
    issue("lsr15",    1, 2'b00, 4'd15, 8'hFF, 0, 8'h00, 0, 16, 0, 2'b10, 0, 0);

    // Stray start during the second RUN cycle must be dropped.
    issue("ignored",  0, 2'b00, 4'd4,  8'h01, 0, 8'h10, 0,  5, 0, 2'b01, 0, 0);
    @(negedge alu_clk);
    start = 1'b1; dir = 1'b1; mode = 2'b11; count = 4'd1; operand = 8'hFF;
    @(negedge alu_clk);
    start = 1'b0;

    // Asynchronous reset in the middle of a count-7 shift aborts it silently.
    issue("aborted",  0, 2'b00, 4'd7,  8'h01, 0, 8'h80, 0,  8, 0, 2'b01, 0, 0);
    repeat (2) @(negedge alu_clk);
    #1;
    alu_rst_n = 1'b0;
    sb.delete();
    dones_expected--;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_result", 32'(result), 32'd0);
    chk("rst_mid_carry", 32'(carry_out), 32'd0);
    chk("rst_mid_op", 32'(lhs_operation), 32'd0);
    chk("rst_mid_lhs_in", 32'(lhs_in), 32'd0);
    chk("rst_mid_lhs_cin", 32'(lhs_carry_in), 32'd0);
    @(negedge alu_clk);
    alu_rst_n = 1'b1;
    repeat (10) @(negedge alu_clk);

    issue("post_rst", 0, 2'b00, 4'd2,  8'hC3, 0, 8'h0C, 1,  3, 1, 2'b01, 0, 0);

    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge alu_clk);
    repeat (5) @(negedge alu_clk);
    chk("outstanding_at_end", 32'(sb.size()), 32'd0);
    chk("done_count", 32'(dones_seen), 32'(dones_expected));
    chk("idle_mirror_lhs_in", 32'(lhs_in), 32'h0C);
    chk("idle_mirror_lhs_out", 32'(lhs_out), 32'h0C);
    chk("idle_mirror_op", 32'(lhs_operation), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/lhs_sequencer.md
# lhs_sequencer

Multi-cycle controller for the ALU left-hand-side shift unit (`lhs`, one-bit shift per `alu_clk` edge, 1-edge registered latency). The block accepts a shift request with an operand, shift count, direction and fill mode. It issues one `lhs` step per cycle, feeding `lhs_out`/`lhs_carry_out` back as the next step's input, and returns the final value and carry with a one-cycle `done` pulse. It sits beside `lhs` in the ALU top level and drives all of its inputs.

## Interface
- `WIDTH`, 8: datapath width; must match `lhs`.
- `CW`, `$clog2(WIDTH)+1`: width of the shift count.
- `alu_clk` in 1: ALU clock, the same clock that drives `lhs`.
- `alu_rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request strobe; accepted only while `busy`=0.
- `dir` in 1: 0 = left, 1 = right.
- `mode` in 2: 00 logical, 01 rotate-through-carry, 10 arithmetic, 11 clear.
- `count` in CW: number of one-bit steps; every value is executed literally, no clamping.
- `operand` in WIDTH: value to shift.
- `carry_in` in 1: initial carry.
- `busy` out 1: request in flight.
- `done` out 1: one-cycle pulse; `result`/`carry_out` are valid and updated this cycle.
- `result` out WIDTH: registered final value; holds until the next `done`.
- `carry_out` out 1: registered final carry (last bit shifted out).
- `lhs_operation` out 2: to `lhs.operation`.
- `lhs_in` out WIDTH: to `lhs.in`.
- `lhs_carry_in` out 1: to `lhs.carry_in`.
- `lhs_out` in WIDTH: from `lhs.out`.
- `lhs_carry_out` in 1: from `lhs.carry_out`.

## Operation
- `lhs` operation encodings: 00 pass, 01 shift left, 10 shift right, 11 zero.
- State machine states: IDLE, RUN, CAPTURE.
- IDLE:
  - Outputs: `lhs_operation`=00, `lhs_in`=`result`, `lhs_carry_in`=`carry_out`, so `lhs_out` mirrors the held result.
  - On `start`, latch operand, count, dir, mode and carry_in; load step counter N; go to RUN.
- Step count N:
  - mode 11: N = 1, op 11.
  - count = 0: N = 1, op 00 (pass).
  - Otherwise: N = count, op 01 if `dir`=0, op 10 if `dir`=1.
- RUN, step k (k = 1..N):
  - `lhs_in` = latched operand when k = 1, else `lhs_out`.
  - `lhs_carry_in` by mode:
    - logical: 0.
    - rotate: latched carry_in at k = 1, else `lhs_carry_out`.
    - arithmetic right: `lhs_in[WIDTH-1]`.
    - arithmetic left: 0, identical to logical.
    - pass step (count = 0): latched carry_in.
    - clear: don't-care.
  - After step N is issued, go to CAPTURE.
- CAPTURE:
  - `result` <= `lhs_out`, `carry_out` <= `lhs_carry_out`, `done` <= 1.
  - `lhs_operation` = 00; go to IDLE.
- `start` while `busy`=1 is ignored. No queueing and no error flag.
- Reset (asynchronous, any state):
  - State = IDLE; `busy`, `done`, `carry_out` = 0; `result` = 0.
  - `lhs_operation` = 00, `lhs_in` = 0, `lhs_carry_in` = 0.
  - An in-flight request is aborted with no `done`.
  - `lhs` has no reset; correctness does not depend on it, because step 1 always sources the latched operand.

## Timing
- Accept edge E0: `busy` rises after E0.
- `lhs` samples step k at edge Ek.
- `result`/`carry_out` update at E(N+1); `done` is high, and `busy` low, during the cycle after E(N+1).
- Latency is N+1 edges from accept to `done`. Examples: clear = 2 edges, count 0 = 2 edges, count 15 = 16 edges.
- `start` in the `done` cycle is accepted, giving back-to-back operation with no bubble beyond CAPTURE.
- `busy` is 1 exactly in the RUN and CAPTURE cycles.

## Structure
- Shared package `lhs_seq_pkg`:
  - `lhs_op_t` (PASS = 00, SHL = 01, SHR = 10, ZERO = 11).
  - `shift_mode_t` (LOGICAL, ROTATE, ARITH, CLEAR).
  - `seq_state_t` (IDLE, RUN, CAPTURE).
- `lhs_op_t` is reused by the ALU top-level decoder.
- Single module, no sub-modules. `lhs` is instantiated by the ALU top level, not inside this block.

## Test plan
- WIDTH=8, logical left, operand 0x81, count 3 -> `lhs_operation` 01 for 3 cycles; `result`=0x08, `carry_out`=0; `done` 4 edges after accept.
- Arithmetic right, operand 0x90, count 2 -> `lhs_carry_in` 1 on both steps; `result`=0xE4, `carry_out`=0.
- Rotate right, operand 0x01, carry_in 1, count 9 -> `result`=0x01, `carry_out`=1; `done` 10 edges after accept.
- count 0, operand 0x5A, carry_in 1 (logical) -> single pass step; `result`=0x5A, `carry_out`=1; clear mode with operand 0xFF -> `result`=0x00, `carry_out`=0, 2-edge latency.
- `start` pulsed at the 2nd RUN cycle -> ignored, one `done` only. New `start` in the `done` cycle -> accepted, `busy` stays 1.
- `alu_rst_n` low mid-RUN of a count-7 shift -> all outputs return to reset values immediately; no `done`. The next request after release completes correctly.
